// File: rtl/btn_debounce_pulse_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// State codes, 100 MHz timing defaults, counter width helper.
package btn_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int DEBOUNCE_DEF      = 500000;
  localparam int REPEAT_DELAY_DEF  = 50000000;
  localparam int REPEAT_PERIOD_DEF = 20000000;

  // Bits needed to hold values 0..n
  function automatic int CNT_W(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int MAX2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_ff.sv
// Multi-flop synchroniser for asynchronous pads.
// Reusable for buttons and switches alike.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Shift the pad value through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Pushbutton conditioner: sync, debounce, press/release pulses.
// Optional auto-repeat pulses while the button stays held.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  localparam int DB_W  = CNT_W(DEBOUNCE_CYCLES);
  localparam int REP_W =
    CNT_W(MAX2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0] DB_ONE =
    DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] RD_LAST =
    REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RP_LAST =
    REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE =
    REP_W'(1);

  logic s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s)
  );

  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_q,    db_d;
  logic [REP_W-1:0]  rep_q,   rep_d;
  logic              phase_q, phase_d;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;
  logic              rel_q,   rel_d;

  // Next-state: debounce counting, repeat timing, pulse requests
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    rep_d   = rep_q;
    phase_d = phase_q;
    level_d = level_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            level_d = 1'b1;
            pulse_d = 1'b1;
            rep_d   = '0;
            db_d    = '0;
          end else begin
            state_d = PRESS_WAIT;
            db_d    = DB_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
          rep_d   = '0;
          db_d    = '0;
        end else begin
          db_d = db_q + DB_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            level_d = 1'b0;
            rel_d   = 1'b1;
            phase_d = 1'b0;
            rep_d   = '0;
            db_d    = '0;
          end else begin
            state_d = REL_WAIT;
            db_d    = DB_ONE;
          end
        end else if (!repeat_en) begin
          rep_d   = '0;
          phase_d = 1'b0;
        end else if (!phase_q && rep_q == RD_LAST) begin
          pulse_d = 1'b1;
          rep_d   = '0;
          phase_d = 1'b1;
        end else if (phase_q && rep_q == RP_LAST) begin
          pulse_d = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + REP_ONE;
        end
      end
      REL_WAIT: begin
        if (s) begin
          state_d = HELD;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
          phase_d = 1'b0;
          rep_d   = '0;
          db_d    = '0;
        end else begin
          db_d = db_q + DB_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        db_d    = '0;
        rep_d   = '0;
        phase_d = 1'b0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      db_q    <= '0;
      rep_q   <= '0;
      phase_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      rep_q   <= rep_d;
      phase_q <= phase_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_release = rel_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed scenarios plus
// randomized bounce against a run-length reference model.
module tb_btn_debounce_pulse;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic repeat_en;
  logic btn_level;
  logic btn_pulse;
  logic btn_release;

  btn_debounce_pulse #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_p = 0;
  int n_r = 0;
  logic prev_p = 1'b0;

  // Reference: delay line for the synchroniser, accepted level,
  // run of samples differing from it, held-time ticks.
  logic m_dl [SYNC];
  logic m_level, m_pulse, m_rel, m_first;
  int   m_run, m_tick;

  task automatic chk(input string tag,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag,
                      input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic e,
                       input logic rs);
    logic s;
    if (rs) begin
      for (int i = 0; i < SYNC; i++) m_dl[i] = 1'b0;
      m_level = 0; m_pulse = 0; m_rel = 0;
      m_run = 0; m_tick = 0; m_first = 1;
      return;
    end
    s = m_dl[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
    m_dl[0] = r;
    m_pulse = 0;
    m_rel = 0;
    if (s != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_run = 0;
        m_level = s;
        if (s) begin
          m_pulse = 1; m_tick = 0; m_first = 1;
        end else begin
          m_rel = 1; m_first = 1;
        end
      end
    end else if (m_run > 0) begin
      m_run = 0;
    end else if (m_level) begin
      if (!e) begin
        m_tick = 0; m_first = 1;
      end else begin
        m_tick++;
        if (m_tick == (m_first ? RD : RP)) begin
          m_pulse = 1; m_tick = 0; m_first = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic rs);
    btn_raw = r;
    repeat_en = e;
    rst = rs;
    @(posedge clk);
    model(r, e, rs);
    #1;
    chk("level", btn_level, m_level);
    chk("pulse", btn_pulse, m_pulse);
    chk("release", btn_release, m_rel);
    chk("pulse_gap", btn_pulse & prev_p, 1'b0);
    if (btn_pulse) n_p++;
    if (btn_release) n_r++;
    prev_p = btn_pulse;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_level", btn_level, 1'b0);
    chk("rst_pulse", btn_pulse, 1'b0);
    chk("rst_rel", btn_release, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int p0, r0, n;
    logic rb, en;
    btn_raw = 1'b0;
    repeat_en = 1'b0;
    rst = 1'b1;

    // Clean press, hold 8, then clean release
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("s1_pulse", btn_pulse, k == 6);
      chk("s1_level", btn_level, k >= 6);
    end
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("s1_rel", btn_release, k == 6);
      chk("s1_rlevel", btn_level, k < 6);
    end

    // Bounce 1,0,1,0 then steady high
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      rb = (k >= 5) ? 1'b1 : ((k % 2) == 1);
      step(rb, 1'b0, 1'b0);
      chk("s2_pulse", btn_pulse, k == 10);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);

    // Hold 40 with auto-repeat
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("s3_rep", btn_pulse,
          k == 6 || (k >= 16 && (k - 16) % 5 == 0));
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0);

    // Hold 40 without auto-repeat
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("s3_norep", btn_pulse, k == 6);
    end

    // Release with a 2-cycle glitch back high
    for (int k = 1; k <= 12; k++) begin
      rb = (k == 2 || k == 3);
      step(rb, 1'b0, 1'b0);
      chk("s4_rel", btn_release, k == 9);
      chk("s4_level", btn_level, k < 9);
      chk("s4_nopulse", btn_pulse, 1'b0);
    end

    // Reset two cycles into press debounce
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 1'b0, (k == 5 || k == 6));
      if (k == 5 || k == 6)
        chk("s5_rstout",
            btn_level | btn_pulse | btn_release, 1'b0);
      chk("s5_pulse", btn_pulse, k == 12);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);

    // Bounce fuzz: 1000 presses, repeat off
    do_reset();
    p0 = n_p;
    r0 = n_r;
    for (int p = 0; p < 1000; p++) begin
      for (int i = 0; i < 3; i++)
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n = 8 + int'($urandom_range(0, 4));
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n = 8 + int'($urandom_range(0, 4));
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    end
    chkn("fuzz_presses", n_p - p0, 1000);
    chkn("fuzz_releases", n_r - r0, 1000);

    // Random segments with repeat_en toggling
    en = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      rb = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 15) == 0) en = ~en;
        step(rb, en, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
